// File: rtl/mostra_sequencia_pkg.sv
// Shared definitions for the sequence presenter: state codes (same encoding as the
// game controller's db_estado), ROM geometry and small helpers.
package mostra_sequencia_pkg;

  localparam int unsigned ROM_LARGURA      = 4;
  localparam int unsigned ROM_PROFUNDIDADE = 16;
  localparam int unsigned ROM_ADDR_W       = $clog2(ROM_PROFUNDIDADE);

  typedef logic [ROM_LARGURA-1:0] item_t;
  typedef logic [ROM_ADDR_W-1:0]  endereco_t;

  typedef enum logic [3:0] {
    INICIAL = 4'h0,
    PREPARA = 4'h1,
    ACENDE  = 4'h2,
    APAGA   = 4'h3,
    PROXIMO = 4'h4,
    FIM     = 4'hF
  } estado_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mostra_sequencia_if.sv
// Control/status bundle between the game controller (master) and the presenter (slave).
// The abortar line exists only when SEQ_ABORT_EN is defined.
interface mostra_sequencia_if;
  import mostra_sequencia_pkg::*;

  logic      iniciar;
  endereco_t limite;
  item_t     leds;
  logic      mostrando;
  logic      pronto;
  endereco_t db_endereco;
  logic [3:0] db_estado;
`ifdef SEQ_ABORT_EN
  logic      abortar;

  modport master (
    output iniciar, limite, abortar,
    input  leds, mostrando, pronto, db_endereco, db_estado
  );

  modport slave (
    input  iniciar, limite, abortar,
    output leds, mostrando, pronto, db_endereco, db_estado
  );
`else
  modport master (
    output iniciar, limite,
    input  leds, mostrando, pronto, db_endereco, db_estado
  );

  modport slave (
    input  iniciar, limite,
    output leds, mostrando, pronto, db_endereco, db_estado
  );
`endif

endinterface

// File: rtl/mostra_sequencia_rom.sv
// Asynchronous-read 16x4 ROM holding the one-hot sequence shown to the player.
module rom_sequencia_16x4
  import mostra_sequencia_pkg::*;
(
  input  endereco_t i_endereco,
  output item_t     o_dado
);

  always_comb begin
    o_dado = '0;
    unique case (i_endereco)
      4'h0: o_dado = 4'h1;
      4'h1: o_dado = 4'h2;
      4'h2: o_dado = 4'h4;
      4'h3: o_dado = 4'h8;
      4'h4: o_dado = 4'h4;
      4'h5: o_dado = 4'h2;
      4'h6: o_dado = 4'h1;
      4'h7: o_dado = 4'h1;
      4'h8: o_dado = 4'h2;
      4'h9: o_dado = 4'h2;
      4'hA: o_dado = 4'h4;
      4'hB: o_dado = 4'h4;
      4'hC: o_dado = 4'h8;
      4'hD: o_dado = 4'h8;
      4'hE: o_dado = 4'h1;
      4'hF: o_dado = 4'h4;
      default: o_dado = '0;
    endcase
  end

endmodule

// File: rtl/mostra_sequencia.sv
// Sequence presenter: lights ROM items 0..limite one at a time with a dark gap after
// each, then pulses pronto. Defining SEQ_ABORT_EN adds the abortar input.
module mostra_sequencia
  import mostra_sequencia_pkg::*;
#(
  parameter int unsigned CICLOS_ACESO   = 1000,
  parameter int unsigned CICLOS_APAGADO = 500
) (
  input  logic              clock,
  input  logic              reset,
  mostra_sequencia_if.slave bus
);

  localparam int unsigned TIMER_W = $clog2(max_u(CICLOS_ACESO, CICLOS_APAGADO)) + 1;
  localparam logic [TIMER_W-1:0] FIM_ACESO   = TIMER_W'(CICLOS_ACESO - 1);
  localparam logic [TIMER_W-1:0] FIM_APAGADO = TIMER_W'(CICLOS_APAGADO - 1);

  estado_t             r_estado, w_estado_prox;
  endereco_t           r_endereco, w_endereco_prox;
  endereco_t           r_limite, w_limite_prox;
  logic [TIMER_W-1:0]  r_timer, w_timer_prox;

  item_t w_rom_dado;
  item_t w_leds;
  logic  w_mostrando;
  logic  w_pronto;

  rom_sequencia_16x4 u_rom (
    .i_endereco (r_endereco),
    .o_dado     (w_rom_dado)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado   <= INICIAL;
      r_endereco <= '0;
      r_limite   <= '0;
      r_timer    <= '0;
    end else begin
      r_estado   <= w_estado_prox;
      r_endereco <= w_endereco_prox;
      r_limite   <= w_limite_prox;
      r_timer    <= w_timer_prox;
    end
  end

  always_comb begin
    w_estado_prox   = r_estado;
    w_endereco_prox = r_endereco;
    w_limite_prox   = r_limite;
    w_timer_prox    = r_timer;

    unique case (r_estado)
      INICIAL: begin
        if (bus.iniciar) w_estado_prox = PREPARA;
      end
      PREPARA: begin
        w_endereco_prox = '0;
        w_timer_prox    = '0;
        w_limite_prox   = bus.limite;
        w_estado_prox   = ACENDE;
      end
      ACENDE: begin
        if (r_timer == FIM_ACESO) begin
          w_timer_prox  = '0;
          w_estado_prox = APAGA;
        end else begin
          w_timer_prox  = r_timer + 1'b1;
        end
      end
      APAGA: begin
        if (r_timer == FIM_APAGADO) begin
          w_timer_prox  = '0;
          w_estado_prox = (r_endereco == r_limite) ? FIM : PROXIMO;
        end else begin
          w_timer_prox  = r_timer + 1'b1;
        end
      end
      PROXIMO: begin
        w_endereco_prox = r_endereco + 1'b1;
        w_estado_prox   = ACENDE;
      end
      FIM: begin
        w_estado_prox = INICIAL;
      end
      default: begin
        w_estado_prox = INICIAL;
      end
    endcase

`ifdef SEQ_ABORT_EN
    // Abort overrides every transition above; limite_reg is left as is since PREPARA reloads it.
    if (bus.abortar && (r_estado != INICIAL)) begin
      w_estado_prox   = INICIAL;
      w_endereco_prox = '0;
      w_timer_prox    = '0;
    end
`endif
  end

  always_comb begin
    w_leds      = '0;
    w_mostrando = 1'b0;
    w_pronto    = 1'b0;
    unique case (r_estado)
      ACENDE: begin
        w_leds      = w_rom_dado;
        w_mostrando = 1'b1;
      end
      APAGA:   w_mostrando = 1'b1;
      PROXIMO: w_mostrando = 1'b1;
      FIM:     w_pronto    = 1'b1;
      default: begin
        w_leds      = '0;
        w_mostrando = 1'b0;
        w_pronto    = 1'b0;
      end
    endcase
  end

  assign bus.leds        = w_leds;
  assign bus.mostrando   = w_mostrando;
  assign bus.pronto      = w_pronto;
  assign bus.db_endereco = r_endereco;
  assign bus.db_estado   = r_estado;

endmodule
